// File: rtl/avalon_arb_pkg.sv
// Shared types and helpers for the multi-channel Avalon-MM arbitrating master.
package avalon_arb_pkg;

  typedef enum logic [1:0] {
    StIdle,
    StXfer,
    StDone
  } arb_state_e;

  localparam int unsigned PRIO_RR    = 0;
  localparam int unsigned PRIO_FIXED = 1;

  // Index width that stays at least one bit for degenerate sizes.
  function automatic int unsigned clog2_min1(input int unsigned n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Combinational channel picker: lock owner, round-robin from a pointer, or fixed priority.
module rr_arbiter
  import avalon_arb_pkg::*;
#(
  parameter int unsigned NCH = 3,
  parameter int unsigned IW  = clog2_min1(NCH)
) (
  input  logic [NCH-1:0] pending,
  input  logic [IW-1:0]  pointer,
  input  logic           mode,
  input  logic           lock_valid,
  input  logic [IW-1:0]  lock_id,
  output logic           valid,
  output logic [IW-1:0]  grant
);

  int unsigned idx;

  always_comb begin
    valid = 1'b0;
    grant = '0;
    idx   = 0;
    if (lock_valid) begin
      // While a lock is held nobody else may win, even if the owner is idle.
      valid = pending[lock_id];
      grant = lock_id;
    end else begin
      for (int unsigned k = 0; k < NCH; k++) begin
        idx = mode ? k : (32'(pointer) + k) % NCH;
        if (!valid && pending[IW'(idx)]) begin
          valid = 1'b1;
          grant = IW'(idx);
        end
      end
    end
  end

endmodule

// File: rtl/avalon_mm_arb_master.sv
// NCH requesters sharing one single-beat Avalon-MM master port, with
// waitrequest timeout and locked request sequences.
module avalon_mm_arb_master
  import avalon_arb_pkg::*;
#(
  parameter int unsigned NCH       = 3,
  parameter int unsigned DW        = 32,
  parameter int unsigned AW        = 32,
  parameter int unsigned PRIO_MODE = PRIO_RR,
  parameter int unsigned TIMEOUT   = 255
) (
  input  logic                       CLK,
  input  logic                       RST_N,
  input  logic [NCH-1:0]             req_start,
  input  logic [NCH-1:0]             req_rnw,
  input  logic [NCH-1:0]             req_lock,
  input  logic [NCH*AW-1:0]          req_addr,
  input  logic [NCH*DW-1:0]          req_wdata,
  output logic [NCH-1:0]             req_done,
  output logic [NCH-1:0]             req_err,
  output logic [DW-1:0]              req_rdata,
  output logic [clog2_min1(NCH)-1:0] grant_id,
  output logic [AW-1:0]              ADDRESS,
  output logic                       BEGINTRANSFER,
  output logic                       READ,
  output logic                       WRITE,
  output logic [DW-1:0]              WRITEDATA,
  output logic                       LOCK,
  input  logic [DW-1:0]              READDATA,
  input  logic                       WAITREQUEST
);

  localparam int unsigned IW = clog2_min1(NCH);
  localparam int unsigned CW = clog2_min1(TIMEOUT + 1);

  arb_state_e     state_q, state_d;
  logic [NCH-1:0] pending_q, pending_d;
  logic [IW-1:0]  ptr_q, ptr_d;
  logic           lock_valid_q, lock_valid_d;
  logic [IW-1:0]  lock_id_q, lock_id_d;
  logic [IW-1:0]  grant_q, grant_d;
  logic [AW-1:0]  addr_q, addr_d;
  logic [DW-1:0]  wdata_q, wdata_d;
  logic [DW-1:0]  rdata_q, rdata_d;
  logic           read_q, read_d;
  logic           write_q, write_d;
  logic           lock_q, lock_d;
  logic           begin_q, begin_d;
  logic           xfer_lock_q, xfer_lock_d;
  logic           err_q, err_d;
  logic [CW-1:0]  cnt_q, cnt_d;

  logic           arb_valid;
  logic [IW-1:0]  arb_grant;
  logic [NCH-1:0] grant_oh;

  rr_arbiter #(
    .NCH (NCH),
    .IW  (IW)
  ) u_arb (
    .pending    (pending_q),
    .pointer    (ptr_q),
    .mode       (PRIO_MODE == PRIO_FIXED),
    .lock_valid (lock_valid_q),
    .lock_id    (lock_id_q),
    .valid      (arb_valid),
    .grant      (arb_grant)
  );

  assign grant_oh = NCH'(1) << grant_q;

  always_comb begin
    state_d      = state_q;
    pending_d    = pending_q | req_start;
    ptr_d        = ptr_q;
    lock_valid_d = lock_valid_q;
    lock_id_d    = lock_id_q;
    grant_d      = grant_q;
    addr_d       = addr_q;
    wdata_d      = wdata_q;
    rdata_d      = rdata_q;
    read_d       = read_q;
    write_d      = write_q;
    lock_d       = lock_q;
    begin_d      = begin_q;
    xfer_lock_d  = xfer_lock_q;
    err_d        = err_q;
    cnt_d        = cnt_q;

    unique case (state_q)
      StIdle: begin
        if (arb_valid) begin
          grant_d     = arb_grant;
          addr_d      = req_addr[32'(arb_grant)*AW +: AW];
          wdata_d     = req_wdata[32'(arb_grant)*DW +: DW];
          read_d      = req_rnw[arb_grant];
          write_d     = ~req_rnw[arb_grant];
          lock_d      = req_lock[arb_grant];
          xfer_lock_d = req_lock[arb_grant];
          begin_d     = 1'b1;
          err_d       = 1'b0;
          cnt_d       = '0;
          state_d     = StXfer;
        end
      end
      StXfer: begin
        begin_d = 1'b0;
        if (!WAITREQUEST) begin
          if (read_q) rdata_d = READDATA;
          read_d  = 1'b0;
          write_d = 1'b0;
          lock_d  = 1'b0;
          cnt_d   = '0;
          state_d = StDone;
        end else if (TIMEOUT != 0 && (32'(cnt_q) + 32'd1) >= TIMEOUT) begin
          read_d  = 1'b0;
          write_d = 1'b0;
          lock_d  = 1'b0;
          rdata_d = '0;
          err_d   = 1'b1;
          cnt_d   = '0;
          state_d = StDone;
        end else if (cnt_q != {CW{1'b1}}) begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      StDone: begin
        // A new start on the finishing channel survives the clear.
        pending_d    = (pending_q & ~grant_oh) | req_start;
        ptr_d        = (32'(grant_q) == NCH - 1) ? '0 : grant_q + 1'b1;
        lock_valid_d = xfer_lock_q & ~err_q;
        lock_id_d    = grant_q;
        state_d      = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state_q      <= StIdle;
      pending_q    <= '0;
      ptr_q        <= '0;
      lock_valid_q <= 1'b0;
      lock_id_q    <= '0;
      grant_q      <= '0;
      addr_q       <= '0;
      wdata_q      <= '0;
      rdata_q      <= '0;
      read_q       <= 1'b0;
      write_q      <= 1'b0;
      lock_q       <= 1'b0;
      begin_q      <= 1'b0;
      xfer_lock_q  <= 1'b0;
      err_q        <= 1'b0;
      cnt_q        <= '0;
    end else begin
      state_q      <= state_d;
      pending_q    <= pending_d;
      ptr_q        <= ptr_d;
      lock_valid_q <= lock_valid_d;
      lock_id_q    <= lock_id_d;
      grant_q      <= grant_d;
      addr_q       <= addr_d;
      wdata_q      <= wdata_d;
      rdata_q      <= rdata_d;
      read_q       <= read_d;
      write_q      <= write_d;
      lock_q       <= lock_d;
      begin_q      <= begin_d;
      xfer_lock_q  <= xfer_lock_d;
      err_q        <= err_d;
      cnt_q        <= cnt_d;
    end
  end

  assign req_done      = (state_q == StDone) ? grant_oh : '0;
  assign req_err       = req_done & {NCH{err_q}};
  assign req_rdata     = rdata_q;
  assign grant_id      = grant_q;
  assign ADDRESS       = addr_q;
  assign BEGINTRANSFER = begin_q;
  assign READ          = read_q;
  assign WRITE         = write_q;
  assign WRITEDATA     = wdata_q;
  assign LOCK          = lock_q;

endmodule
